// File: rtl/svm_pkg.sv
// svm_pkg: shared fixed-point widths, feature/coefficient types, strobe bundle and feeder FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svm_pkg;

  localparam int FEA_I_DEF  = 4;
  localparam int FEA_F_DEF  = 8;
  localparam int FEA_W_DEF  = FEA_I_DEF + FEA_F_DEF;
  localparam int COEF_W_DEF = FEA_W_DEF;

  typedef logic signed [FEA_W_DEF-1:0]  fea_t;
  typedef logic signed [COEF_W_DEF-1:0] coef_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  // One slot of the term pipeline: a real beat, and whether it opens/closes a block.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } strb_t;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svm_feeder_strb.sv
// svm_feeder_strb: carries {valid, first, last} of each accepted beat to the PE init/accumulate strobes.
// Latency: init (and blk_inc) 2 cycles after acceptance, accumulate 3 cycles after.
// Backpressure: none; free-running shift, bubbles travel through as vld=0.
// Ports: clk/rst_n; beat/first/last from the acceptance cycle; init, accumulate, blk_inc out.
module svm_feeder_strb
  import svm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic beat,
  input  logic first,
  input  logic last,
  output logic init,
  output logic accumulate,
  output logic blk_inc
);

  strb_t s1_q;
  strb_t s2_q;
  logic  acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      acc_q <= 1'b0;
    end else begin
      s1_q  <= '{vld: beat, first: first, last: last};
      s2_q  <= s1_q;
      acc_q <= s2_q.vld & s2_q.last;
    end
  end

  // init lines up with the coefficient returned by the RAM; accumulate trails
  // by one so the PE has folded in the block's last product first.
  assign init       = s2_q.vld & s2_q.first;
  // Block count moves on the edge that raises accumulate, so both appear together.
  assign blk_inc    = s2_q.vld & s2_q.last;
  assign accumulate = acc_q;

endmodule

// File: rtl/svm_feeder.sv
// svm_feeder: sequences one detection window of HOG features into an svm_pe chain (feature, coefficient, strobes).
// Latency: fea/coef_addr 1 cycle after accept, coef/init 2 cycles, accumulate/blk_cnt 3 cycles.
// Backpressure: s_ready is high throughout RUN only (registered state, no s_valid path); gaps insert zero terms.
// Ports: start/s_valid/s_ready/s_fea stream in; coef_addr/coef_rdata RAM; fea/coef/init/accumulate to PEs;
//        blk_cnt/busy/done status. Build option SVM_FEEDER_STALL_CNT_EN adds a 16-bit stall_cnt output.
module svm_feeder
  import svm_pkg::*;
#(
  parameter int FEA_I  = FEA_I_DEF,
  parameter int FEA_F  = FEA_F_DEF,
  parameter int NUM_PE = 8,
  parameter int N_FEA  = 36,
  parameter int N_BLK  = 105,
  localparam int FEA_W  = FEA_I + FEA_F,
  localparam int COEF_W = FEA_W,
  localparam int ADDR_W = $clog2(N_FEA * N_BLK),
  localparam int BC_W   = $clog2(N_BLK + 1)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEA_W-1:0]         s_fea,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [NUM_PE*COEF_W-1:0] coef_rdata,
  output logic [FEA_W-1:0]         fea,
  output logic [NUM_PE*COEF_W-1:0] coef,
  output logic                     init,
  output logic                     accumulate,
  output logic [BC_W-1:0]          blk_cnt,
  output logic                     busy,
  output logic                     done
`ifdef SVM_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int K_W = cnt_w(N_FEA);
  localparam int B_W = cnt_w(N_BLK);

  state_t            state_q, state_d;
  logic              flush_q;
  logic [K_W-1:0]    k_q;
  logic [B_W-1:0]    b_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              first_beat;
  logic              last_beat;
  logic              final_beat;
  logic              win_start;
  logic              blk_inc;

  assign accept     = s_valid & s_ready;
  assign first_beat = (k_q == '0);
  assign last_beat  = (k_q == K_W'(N_FEA - 1));
  assign final_beat = last_beat && (b_q == B_W'(N_BLK - 1));
  assign win_start  = (state_q == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        s_ready = 1'b1;
        if (s_valid && final_beat) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q   <= 1'b0;
      k_q       <= '0;
      b_q       <= '0;
      addr_q    <= '0;
      coef_addr <= '0;
      fea       <= '0;
      blk_cnt   <= '0;
    end else begin
      // A bubble drives a zero feature so the PE adds a zero product.
      fea     <= accept ? s_fea : '0;
      // Second FLUSH cycle is marked by flush_q.
      flush_q <= (state_q == S_FLUSH) && !flush_q;
      if (win_start) begin
        k_q     <= '0;
        b_q     <= '0;
        addr_q  <= '0;
        blk_cnt <= '0;
      end else begin
        if (accept) begin
          // addr_q == b*N_FEA + k: one linear count of accepted beats per window.
          coef_addr <= addr_q;
          addr_q    <= addr_q + 1'b1;
          if (last_beat) begin
            k_q <= '0;
            b_q <= b_q + 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        if (blk_inc) blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  assign coef = coef_rdata;

  svm_feeder_strb u_strb (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat       (accept),
    .first      (first_beat),
    .last       (last_beat),
    .init       (init),
    .accumulate (accumulate),
    .blk_inc    (blk_inc)
  );

`ifdef SVM_FEEDER_STALL_CNT_EN
  logic seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      stall_cnt <= '0;
    end else if (win_start) begin
      seen_q    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept) seen_q <= 1'b1;
      // Starvation is only counted once the source has begun delivering.
      if ((state_q == S_RUN) && seen_q && !s_valid && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_svm_feeder.sv
module tb_svm_feeder;

  localparam int N_FEA  = 4;
  localparam int N_BLK  = 2;
  localparam int TOTAL  = N_FEA * N_BLK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_fea;
  logic [2:0]  coef_addr;
  logic [11:0] coef_rdata;
  logic [11:0] fea;
  logic [11:0] coef;
  logic        init;
  logic        accumulate;
  logic [1:0]  blk_cnt;
  logic        busy;
  logic        done;
`ifdef SVM_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  svm_feeder #(
    .FEA_I(4), .FEA_F(8), .NUM_PE(1), .N_FEA(N_FEA), .N_BLK(N_BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_fea      (s_fea),
    .coef_addr  (coef_addr),
    .coef_rdata (coef_rdata),
    .fea        (fea),
    .coef       (coef),
    .init       (init),
    .accumulate (accumulate),
    .blk_cnt    (blk_cnt),
    .busy       (busy),
    .done       (done)
`ifdef SVM_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous coefficient RAM with RAM[a] = a+1.
  always @(posedge clk) coef_rdata <= 12'(coef_addr) + 12'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: per-beat schedule of expected outputs ----------------
  typedef enum int {M_IDLE, M_RUN, M_FLUSH, M_DONE} mph_t;
  mph_t m_ph;
  int   m_fl, m_beats, m_addr, m_blk;
  int   fea_s [8];
  bit   init_s[8];
  bit   acc_s [8];
  bit   coef_v[8];
  int   coef_s[8];
  bit   addr_v[8];
  int   addr_s[8];

  always @(negedge clk) begin : model
    int sl;
    int j;
    sl = cyc % 8;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        fea_s[i] = 0; init_s[i] = 0; acc_s[i] = 0;
        coef_v[i] = 0; coef_s[i] = 0; addr_v[i] = 0; addr_s[i] = 0;
      end
      m_ph = M_IDLE; m_fl = 0; m_beats = 0; m_addr = 0; m_blk = 0;
    end else begin
      if (addr_v[sl]) m_addr = addr_s[sl];
      if (acc_s[sl])  m_blk++;
    end
    chk("s_ready",    s_ready,    m_ph == M_RUN);
    chk("busy",       busy,       m_ph != M_IDLE);
    chk("done",       done,       m_ph == M_DONE);
    chk("fea",        fea,        fea_s[sl]);
    chk("coef_addr",  coef_addr,  m_addr);
    chk("init",       init,       init_s[sl]);
    chk("accumulate", accumulate, acc_s[sl]);
    chk("blk_cnt",    blk_cnt,    m_blk);
    if (coef_v[sl]) chk("coef", coef, coef_s[sl]);
    fea_s[sl] = 0; init_s[sl] = 0; acc_s[sl] = 0; coef_v[sl] = 0; addr_v[sl] = 0;
    if (rst_n) begin
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_RUN; m_beats = 0; m_blk = 0; end
        M_RUN: if (s_valid) begin
          j = m_beats;
          fea_s[(cyc + 1) % 8]  = int'(s_fea);
          addr_v[(cyc + 1) % 8] = 1; addr_s[(cyc + 1) % 8] = j;
          init_s[(cyc + 2) % 8] = (j % N_FEA == 0);
          coef_v[(cyc + 2) % 8] = 1; coef_s[(cyc + 2) % 8] = j + 1;
          acc_s[(cyc + 3) % 8]  = (j % N_FEA == N_FEA - 1);
          m_beats++;
          if (m_beats == TOTAL) begin m_ph = M_FLUSH; m_fl = 2; end
        end
        M_FLUSH: begin m_fl--; if (m_fl == 0) m_ph = M_DONE; end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // ---------------- event log and a PE model fed from the DUT outputs ----------------
  int init_log[$];
  int acc_log[$];
  int done_log[$];
  int pe_sums[$];
  int addr_at[int];
  int fea_at[int];
  int pe_fea_d;
  int pe_acc;

  always @(negedge clk) begin : logger
    int prod;
    if (!rst_n) begin
      pe_fea_d = 0;
      pe_acc   = 0;
    end else begin
      if (init)       init_log.push_back(cyc);
      if (accumulate) acc_log.push_back(cyc);
      if (done)       done_log.push_back(cyc);
      addr_at[cyc] = int'(coef_addr);
      fea_at[cyc]  = int'(fea);
      // PE registers the feature one cycle, multiplies with the current coefficient.
      prod = pe_fea_d * int'(coef);
      if (accumulate) pe_sums.push_back(pe_acc);
      if (init) pe_acc = prod;
      else      pe_acc = pe_acc + prod;
      pe_fea_d = int'($signed(fea));
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int addr_get(input int c);
    return addr_at.exists(c) ? addr_at[c] : -1;
  endfunction

  function automatic int fea_get(input int c);
    return fea_at.exists(c) ? fea_at[c] : -1;
  endfunction

  task automatic clear_logs();
    init_log.delete(); acc_log.delete(); done_log.delete(); pe_sums.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("wait_done", n < lim, 1);
  endtask

  // 1.0 x coefficients 1..4 = 2560 raw (10.0); block 1: 1.0 x 5..8 = 6656 raw (26.0).
  task automatic chk_sums(input string tag);
    chk({tag, "_nsums"}, pe_sums.size(), 2);
    chk({tag, "_sum0"},  qget(pe_sums, 0), 2560);
    chk({tag, "_sum1"},  qget(pe_sums, 1), 6656);
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s;
    int a;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_fea = 12'h000;
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_addr",    coef_addr, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // s_valid with no start: nothing is accepted.
    clear_logs();
    s_valid = 1'b1; s_fea = 12'h100;
    repeat (5) step();
    chk("nostart_ready", s_ready, 0);
    chk("nostart_fea",   fea, 0);
    chk("nostart_strb",  init_log.size() + acc_log.size(), 0);

    // Gap-free window. Last beats of the blocks are at a+3 and a+7, so
    // accumulate lands at a+6 and a+10; done follows the two FLUSH cycles.
    clear_logs();
    start = 1'b1; s = cyc; step(); start = 1'b0;
    a = s + 1;
    wait_done(60);
    s_valid = 1'b0; step(); step();
    chk("A_init0", qget(init_log, 0), a + 2);
    chk("A_init1", qget(init_log, 1), a + 6);
    chk("A_ninit", init_log.size(), 2);
    chk("A_acc0",  qget(acc_log, 0), a + 6);
    chk("A_acc1",  qget(acc_log, 1), a + 10);
    chk("A_done",  qget(done_log, 0), a + 10);
    for (int i = 0; i < TOTAL; i++) chk("A_addr_seq", addr_get(a + 1 + i), i);
    chk("A_blk_cnt", blk_cnt, 2);
    chk_sums("A");

    // Window with a 3-cycle gap between k=1 and k=2 (and a starved first RUN cycle).
    clear_logs();
    repeat (3) step();
    start = 1'b1; s = cyc; step(); start = 1'b0;
    step();
    a = s + 2;
    s_valid = 1'b1; step(); step();
    s_valid = 1'b0; repeat (3) step();
    s_valid = 1'b1;
    wait_done(60);
    s_valid = 1'b0; step(); step();
    chk("B_addr_hold_a", addr_get(a + 2), 1);
    chk("B_addr_hold_b", addr_get(a + 5), 1);
    chk("B_addr_next",   addr_get(a + 6), 2);
    chk("B_fea_gap",     fea_get(a + 4), 0);
    chk("B_fea_beat",    fea_get(a + 1), 12'h100);
    chk("B_ninit",       init_log.size(), 2);
    chk("B_nacc",        acc_log.size(), 2);
    chk_sums("B");
`ifdef SVM_FEEDER_STALL_CNT_EN
    chk("B_stall_cnt", stall_cnt, 3);
`endif

    // start while busy, and again during the DONE cycle.
    clear_logs();
    s_valid = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(60);
    start = 1'b1; step(); start = 1'b0;
    s_valid = 1'b0;
    repeat (6) step();
    chk("C_ndone",   done_log.size(), 1);
    chk("C_blk_cnt", blk_cnt, 2);
    chk("C_busy",    busy, 0);
    chk_sums("C");

    // Reset mid-block at k=2, b=1, then a fresh window.
    clear_logs();
    s_valid = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk("D_rst_fea",   fea, 0);
    chk("D_rst_init",  init, 0);
    chk("D_rst_acc",   accumulate, 0);
    chk("D_rst_busy",  busy, 0);
    chk("D_rst_ready", s_ready, 0);
    chk("D_rst_addr",  coef_addr, 0);
    chk("D_rst_blk",   blk_cnt, 0);
`ifdef SVM_FEEDER_STALL_CNT_EN
    chk("D_rst_stall", stall_cnt, 0);
`endif
    step();
    rst_n = 1'b1;
    clear_logs();
    repeat (8) step();
    chk("D_no_acc", acc_log.size(), 0);
    chk("D_idle",   busy, 0);
    clear_logs();
    start = 1'b1; s = cyc; step(); start = 1'b0;
    a = s + 1;
    wait_done(60);
    s_valid = 1'b0; step(); step();
    chk("D_addr0",   addr_get(a + 1), 0);
    chk("D_init0",   qget(init_log, 0), a + 2);
    chk("D_ndone",   done_log.size(), 1);
    chk("D_blk_cnt", blk_cnt, 2);
    chk_sums("D");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
